// File: rtl/mi_arb_pkg.sv
// Shared definitions for the mi_* bus arbiter: FSM states and arbitration modes.
package mi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

// File: rtl/mi_arb_pick.sv
// Combinational winner selection: round-robin from ptr+1 or fixed lowest index.
module mi_arb_pick
  import mi_arb_pkg::*;
#(
  parameter int N        = 2,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Walk candidates in priority order; the first requester found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (ARB_MODE == ARB_FIXED)
        cand = IW'(k);
      else
        cand = IW'((32'(ptr) + k + 32'd1) % N);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mi_arbiter.sv
// N-way burst arbiter in front of a single memory controller on the mi_* bus.
module mi_arbiter
  import mi_arb_pkg::*;
#(
  parameter int N        = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LW       = 7,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*AW-1:0]   m_addr,
  input  logic [N*LW-1:0]   m_len,
  input  logic [N-1:0]      m_rw,
  input  logic [N-1:0]      m_valid,
  output logic [N-1:0]      m_ready,
  input  logic [N*DW-1:0]   m_wdata,
  output logic [N-1:0]      m_wack,
  output logic [N*DW-1:0]   m_rdata,
  output logic [N-1:0]      m_rstb,
  output logic [AW-1:0]     mi_addr,
  output logic [LW-1:0]     mi_len,
  output logic              mi_rw,
  output logic              mi_valid,
  input  logic              mi_ready,
  output logic [DW-1:0]     mi_wdata,
  input  logic              mi_wack,
  input  logic [DW-1:0]     mi_rdata,
  input  logic              mi_rstb
);

  localparam int IW = $clog2(N);

  arb_state_e    state, state_nx;
  logic [IW-1:0] owner, ptr, win_idx;
  logic [N-1:0]  win_grant;
  logic          win_any;
  logic [LW-1:0] cnt;
  logic          accept;
  logic          beat;

  mi_arb_pick #(
    .N        (N),
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .req   (m_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // A command is accepted only from IDLE and never while reset is asserted,
  // so no master sees a ready pulse for a command that reset discards.
  assign accept = (state == ST_IDLE) && win_any && !rst;
  // Only the strobe matching the burst direction counts as a beat.
  assign beat   = mi_rw ? mi_rstb : mi_wack;

  assign mi_wdata = m_wdata[owner*DW +: DW];
  assign m_rdata  = {N{mi_rdata}};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state: IDLE -> CMD on accept, CMD -> DATA on mi_ready, DATA -> IDLE on last beat.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)              state_nx = ST_CMD;
      ST_CMD:  if (mi_ready)            state_nx = ST_DATA;
      ST_DATA: if (beat && cnt == '0)   state_nx = ST_IDLE;
      default:                          state_nx = ST_IDLE;
    endcase
  end

  // Outputs: ready pulse to the winner, command valid in CMD, beat strobes to the owner.
  always_comb begin
    m_ready  = accept ? win_grant : '0;
    mi_valid = (state == ST_CMD);
    m_wack   = '0;
    m_rstb   = '0;
    if (state == ST_DATA && beat) begin
      if (mi_rw) m_rstb[owner] = 1'b1;
      else       m_wack[owner] = 1'b1;
    end
  end

  // Command capture, owner/pointer tracking and beat countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      mi_addr <= '0;
      mi_len  <= '0;
      mi_rw   <= 1'b0;
      owner   <= '0;
      ptr     <= IW'(N - 1);
      cnt     <= '0;
    end else if (accept) begin
      mi_addr <= m_addr[win_idx*AW +: AW];
      mi_len  <= m_len[win_idx*LW +: LW];
      mi_rw   <= m_rw[win_idx];
      owner   <= win_idx;
      cnt     <= m_len[win_idx*LW +: LW];
      if (ARB_MODE == ARB_RR) ptr <= win_idx;
    end else if (state == ST_DATA && beat && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_mi_arbiter.sv
// Randomized self-checking bench for mi_arbiter: one round-robin and one
// fixed-priority instance (N=4), selected by 'sel', against a burst-level model.
module tb_mi_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 7;

  logic clk = 1'b0;
  logic rst;
  logic sel;  // 0: round-robin instance, 1: fixed-priority instance

  logic [N*AW-1:0] m_addr;
  logic [N*LW-1:0] m_len;
  logic [N-1:0]    m_rw, m_valid;
  logic [N*DW-1:0] m_wdata;
  logic            mi_ready, mi_wack, mi_rstb;
  logic [DW-1:0]   mi_rdata;

  logic [N-1:0]    r_valid, f_valid;
  logic            r_mir, f_mir, r_wack, f_wack, r_rstb, f_rstb;

  logic [N-1:0]    r_m_ready, f_m_ready, r_m_wack, f_m_wack, r_m_rstb, f_m_rstb;
  logic [N*DW-1:0] r_m_rdata, f_m_rdata;
  logic [AW-1:0]   r_mi_addr, f_mi_addr;
  logic [LW-1:0]   r_mi_len, f_mi_len;
  logic            r_mi_rw, f_mi_rw, r_mi_valid, f_mi_valid;
  logic [DW-1:0]   r_mi_wdata, f_mi_wdata;

  logic [N-1:0]    o_m_ready, o_m_wack, o_m_rstb;
  logic [N*DW-1:0] o_m_rdata;
  logic [AW-1:0]   o_mi_addr;
  logic [LW-1:0]   o_mi_len;
  logic            o_mi_rw, o_mi_valid;
  logic [DW-1:0]   o_mi_wdata;

  assign r_valid = sel ? '0 : m_valid;
  assign f_valid = sel ? m_valid : '0;
  assign r_mir   = !sel && mi_ready;
  assign f_mir   =  sel && mi_ready;
  assign r_wack  = !sel && mi_wack;
  assign f_wack  =  sel && mi_wack;
  assign r_rstb  = !sel && mi_rstb;
  assign f_rstb  =  sel && mi_rstb;

  assign o_m_ready  = sel ? f_m_ready  : r_m_ready;
  assign o_m_wack   = sel ? f_m_wack   : r_m_wack;
  assign o_m_rstb   = sel ? f_m_rstb   : r_m_rstb;
  assign o_m_rdata  = sel ? f_m_rdata  : r_m_rdata;
  assign o_mi_addr  = sel ? f_mi_addr  : r_mi_addr;
  assign o_mi_len   = sel ? f_mi_len   : r_mi_len;
  assign o_mi_rw    = sel ? f_mi_rw    : r_mi_rw;
  assign o_mi_valid = sel ? f_mi_valid : r_mi_valid;
  assign o_mi_wdata = sel ? f_mi_wdata : r_mi_wdata;

  mi_arbiter #(.N(N), .AW(AW), .DW(DW), .LW(LW), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_len(m_len), .m_rw(m_rw),
    .m_valid(r_valid), .m_ready(r_m_ready), .m_wdata(m_wdata), .m_wack(r_m_wack),
    .m_rdata(r_m_rdata), .m_rstb(r_m_rstb), .mi_addr(r_mi_addr), .mi_len(r_mi_len),
    .mi_rw(r_mi_rw), .mi_valid(r_mi_valid), .mi_ready(r_mir), .mi_wdata(r_mi_wdata),
    .mi_wack(r_wack), .mi_rdata(mi_rdata), .mi_rstb(r_rstb)
  );

  mi_arbiter #(.N(N), .AW(AW), .DW(DW), .LW(LW), .ARB_MODE(1)) u_fx (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_len(m_len), .m_rw(m_rw),
    .m_valid(f_valid), .m_ready(f_m_ready), .m_wdata(m_wdata), .m_wack(f_m_wack),
    .m_rdata(f_m_rdata), .m_rstb(f_m_rstb), .mi_addr(f_mi_addr), .mi_len(f_mi_len),
    .mi_rw(f_mi_rw), .mi_valid(f_mi_valid), .mi_ready(f_mir), .mi_wdata(f_mi_wdata),
    .mi_wack(f_wack), .mi_rdata(mi_rdata), .mi_rstb(f_rstb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Burst-level reference: phase 0 idle / 1 command / 2 data, beats still owed.
  int            ph, own, ptr, left;
  logic [AW-1:0] c_addr;
  logic [LW-1:0] c_len;
  logic          c_rw;
  logic [N-1:0]  last_er;
  int            glog[$];
  int            n_rstb, n_wack;

  // Stimulus knobs.
  logic [N-1:0] k_mask;
  logic         k_always, k_withdraw, k_stray, k_wrand;
  int           k_lenmax;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    int j;
    if (sel) begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (ptr + k) % N;
        if (v[j]) return j;
      end
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    int           win;
    logic [N-1:0] oh, er, ew, es;
    logic         beat;
    #1;
    win = (ph == 0 && !rst) ? pick(m_valid) : -1;
    oh  = N'(1) << own;
    er  = (win >= 0) ? (N'(1) << win) : '0;
    ew  = (ph == 2 && !c_rw && mi_wack) ? oh : '0;
    es  = (ph == 2 &&  c_rw && mi_rstb) ? oh : '0;
    chk("m_ready",  o_m_ready,  er);
    chk("mi_valid", o_mi_valid, ph == 1);
    chk("mi_addr",  o_mi_addr,  c_addr);
    chk("mi_len",   o_mi_len,   c_len);
    chk("mi_rw",    o_mi_rw,    c_rw);
    chk("m_wack",   o_m_wack,   ew);
    chk("m_rstb",   o_m_rstb,   es);
    chk("mi_wdata", o_mi_wdata, m_wdata[own*DW +: DW]);
    chk("m_rdata",  o_m_rdata,  {N{mi_rdata}});
    last_er = er;
    for (int i = 0; i < N; i++) if (o_m_ready[i]) glog.push_back(i);
    n_rstb += $countones(o_m_rstb);
    n_wack += $countones(o_m_wack);
    @(posedge clk);
    if (rst) begin
      ph = 0; own = 0; ptr = N - 1; left = 0;
      c_addr = '0; c_len = '0; c_rw = 1'b0;
    end else begin
      case (ph)
        0: if (win >= 0) begin
          own    = win;
          if (!sel) ptr = win;
          c_addr = m_addr[win*AW +: AW];
          c_len  = m_len[win*LW +: LW];
          c_rw   = m_rw[win];
          left   = int'(c_len) + 1;
          ph     = 1;
        end
        1: if (mi_ready) ph = 2;
        default: begin
          beat = c_rw ? mi_rstb : mi_wack;
          if (beat) begin
            left--;
            if (left == 0) ph = 0;
          end
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic newreq(input int i);
    m_addr[i*AW +: AW] = $urandom;
    m_len[i*LW +: LW]  = LW'($urandom_range(0, k_lenmax));
    m_rw[i]            = 1'($urandom_range(0, 1));
    m_valid[i]         = 1'b1;
  endtask

  // One cycle of random master and controller behaviour.
  task automatic cyc();
    for (int i = 0; i < N; i++) begin
      if (k_mask[i] && !m_valid[i] && (k_always || $urandom_range(0, 3) == 0))
        newreq(i);
      else if (m_valid[i] && k_withdraw && $urandom_range(0, 31) == 0)
        m_valid[i] = 1'b0;
    end
    if (k_wrand) m_wdata = {$urandom, $urandom, $urandom, $urandom};
    mi_rdata = $urandom;
    mi_ready = 1'($urandom_range(0, 1));
    if (k_stray) begin
      mi_wack = 1'($urandom_range(0, 1));
      mi_rstb = 1'($urandom_range(0, 1));
    end else begin
      mi_wack = (ph == 2 && !c_rw) ? 1'($urandom_range(0, 1)) : 1'b0;
      mi_rstb = (ph == 2 &&  c_rw) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    step();
    m_valid &= ~last_er;
  endtask

  task automatic drain();
    int n;
    k_mask  = '0;
    m_valid = '0;
    n = 0;
    while (ph != 0 && n < 3000) begin
      cyc();
      n++;
    end
    chk("drain_timeout", n < 3000, 1'b1);
    cyc();
  endtask

  // Run until the single queued burst has gone out and completed.
  task automatic one_burst(input string tag);
    int n;
    logic started;
    n = 0;
    started = 1'b0;
    while (n < 3000) begin
      cyc();
      n++;
      if (ph != 0) started = 1'b1;
      else if (started) break;
    end
    chk(tag, n < 3000, 1'b1);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    m_valid = '0; mi_ready = 1'b0; mi_wack = 1'b0; mi_rstb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ph = 0; own = 0; ptr = N - 1; left = 0;
    c_addr = '0; c_len = '0; c_rw = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   c3;
    sel = 1'b0;
    m_addr = '0; m_len = '0; m_rw = '0; m_wdata = '0; mi_rdata = '0;
    k_mask = '0; k_always = 0; k_withdraw = 0; k_stray = 0; k_wrand = 1; k_lenmax = 7;
    n_rstb = 0; n_wack = 0;
    hard_reset();

    // Reset state with every master requesting: no ready pulse, outputs idle.
    for (int i = 0; i < N; i++) newreq(i);
    step();
    step();
    rst = 1'b0;
    glog.delete();
    step();
    chk("first_grant_m0", (glog.size() > 0) ? glog[0] : -1, 0);
    m_valid &= ~last_er;

    // Round-robin random traffic with withdrawals and stray strobes.
    k_mask = '1; k_withdraw = 1; k_stray = 1; k_lenmax = 7;
    repeat (1500) cyc();
    drain();

    // Masters 0 and 1 requesting back-to-back: grants must alternate.
    k_withdraw = 0; k_stray = 0;
    glog.delete();
    k_mask = 4'b0011; k_always = 1;
    repeat (300) cyc();
    k_always = 0;
    drain();
    ok = (glog.size() >= 4);
    for (int i = 0; i < glog.size(); i++) begin
      if (glog[i] > 1) ok = 1'b0;
      if (i > 0 && glog[i] == glog[i-1]) ok = 1'b0;
    end
    chk("rr_alternate", ok, 1'b1);

    // Longest burst: read len=127 from m0 with stray write strobes throughout.
    k_stray = 1;
    m_addr[0 +: AW] = 32'h0000_0100;
    m_len[0 +: LW]  = 7'd127;
    m_rw[0]         = 1'b1;
    m_valid[0]      = 1'b1;
    n_rstb = 0;
    one_burst("len127_timeout");
    chk("len127_beats", n_rstb, 128);
    drain();

    // Single-beat write from m2 with fixed write data.
    k_stray = 0; k_wrand = 0;
    m_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
    m_len[2*LW +: LW]   = '0;
    m_rw[2]             = 1'b0;
    m_valid[2]          = 1'b1;
    n_wack = 0;
    one_burst("wr_len0_timeout");
    chk("wr_len0_wacks", n_wack, 1);
    chk("wr_len0_wdata", o_mi_wdata, 32'hDEAD_BEEF);
    k_wrand = 1;
    drain();

    // Reset after 2 of 8 read beats: burst aborted, pointer back to N-1.
    m_addr[0 +: AW] = 32'h0000_0100;
    m_len[0 +: LW]  = 7'd7;
    m_rw[0]         = 1'b1;
    m_valid[0]      = 1'b1;
    n_rstb = 0;
    begin
      int n;
      n = 0;
      while (n_rstb < 2 && n < 500) begin
        cyc();
        n++;
      end
      chk("rst_mid_timeout", n < 500, 1'b1);
    end
    rst = 1'b1; mi_rstb = 1'b0; mi_wack = 1'b0; mi_ready = 1'b0;
    step();
    rst = 1'b0; mi_rstb = 1'b1;
    #1;
    chk("rst_no_rstb",  o_m_rstb,   '0);
    chk("rst_no_valid", o_mi_valid, 1'b0);
    chk("rst_addr",     o_mi_addr,  '0);
    chk("rst_len",      o_mi_len,   '0);
    step();
    mi_rstb = 1'b0;
    for (int i = 0; i < N; i++) newreq(i);
    glog.delete();
    step();
    chk("rst_ptr_grant", (glog.size() > 0) ? glog[0] : -1, 0);
    m_valid &= ~last_er;
    drain();

    // Fixed-priority instance: random traffic, then starvation of m3 by m1.
    sel = 1'b1;
    hard_reset();
    rst = 1'b0;
    k_mask = '1; k_withdraw = 1; k_stray = 1; k_lenmax = 7;
    repeat (1500) cyc();
    drain();
    k_withdraw = 0; k_stray = 0;
    glog.delete();
    k_mask = 4'b1010; k_always = 1;
    repeat (300) cyc();
    k_always = 0;
    drain();
    ok = (glog.size() >= 3);
    c3 = 0;
    foreach (glog[i]) begin
      if (glog[i] != 1) ok = 1'b0;
      if (glog[i] == 3) c3++;
    end
    chk("fixed_m1_wins", ok, 1'b1);
    chk("fixed_m3_starves", c3, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
